// File: rtl/pcihellocore_button_debounce.sv
// Push-button conditioning: 2-FF sync, per-key debounce, press pulse and wrapping
// 6-bit press counters packed into a 32-bit status word for the button PIO.
module pcihellocore_button_debounce #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] keys_n,
   output logic [31:0]      out_port,
   output logic [WIDTH-1:0] pressed_pulse
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchroniser holds the raw active-low level; reset value 1 means released.
   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] r_level;
   logic [WIDTH-1:0] r_pulse;
   logic [CNT_W-1:0] r_cnt       [WIDTH];
   logic [5:0]       r_press_cnt [WIDTH];

   logic [WIDTH-1:0] w_key;
   logic [WIDTH-1:0] w_stable_d;
   logic [CNT_W-1:0] w_cnt_d     [WIDTH];
   logic [WIDTH-1:0] w_press;
   logic [31:0]      w_out;

   assign w_key   = ~r_s2;
   // r_level lags r_stable by one clock, so a 0->1 difference marks a press.
   assign w_press = r_stable & ~r_level;

   always_comb begin
      w_stable_d = r_stable;
      for (int i = 0; i < WIDTH; i++) begin
         w_cnt_d[i] = r_cnt[i];
         if (w_key[i] == r_stable[i]) begin
            w_cnt_d[i] = '0;
         end else if (r_cnt[i] == CNT_MAX) begin
            w_stable_d[i] = w_key[i];
            w_cnt_d[i]    = '0;
         end else begin
            w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1     <= '1;
         r_s2     <= '1;
         r_stable <= '0;
         r_level  <= '0;
         r_pulse  <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i]       <= '0;
            r_press_cnt[i] <= '0;
         end
      end else begin
         r_s1     <= keys_n;
         r_s2     <= r_s1;
         r_stable <= w_stable_d;
         r_level  <= r_stable;
         r_pulse  <= w_press;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i]       <= w_cnt_d[i];
            r_press_cnt[i] <= r_press_cnt[i] + 6'(w_press[i]);
         end
      end
   end

   // Every field is a flop output; unused key slots stay 0.
   always_comb begin
      w_out = '0;
      w_out[WIDTH-1:0] = r_level;
      for (int i = 0; i < WIDTH; i++) begin
         w_out[8 + 6*i +: 6] = r_press_cnt[i];
      end
   end

   assign out_port      = w_out;
   assign pressed_pulse = r_pulse;

endmodule

// File: tb/tb_pcihellocore_button_debounce.sv
// Bench for pcihellocore_button_debounce: vector table plus corner sequences,
// expected words queued at drive time and compared at the cycle they are due.
module tb_pcihellocore_button_debounce;

   localparam int D    = 4;
   localparam int HOLD = 2 * D + 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  keys_n;
   logic [31:0] out_port;
   logic [3:0]  pressed_pulse;

   int unsigned cyc      = 0;
   int          n_tests  = 0;
   int          n_fail   = 0;
   int          n_pulse2 = 0;
   logic [31:0] exp_cur  = 32'h0;

   typedef struct {
      int unsigned at;
      logic [31:0] out;
      logic [3:0]  pulse;
   } exp_t;

   typedef struct {
      logic [3:0]  kn;
      logic [31:0] eo;
      logic [3:0]  ep;
   } vec_t;

   exp_t sb[$];
   vec_t vt[6];

   pcihellocore_button_debounce #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .keys_n        (keys_n),
      .out_port      (out_port),
      .pressed_pulse (pressed_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act_o, input logic [31:0] exp_o,
                        input logic [3:0] act_p, input logic [3:0] exp_p);
      n_tests++;
      if (act_o !== exp_o || act_p !== exp_p) begin
         n_fail++;
         $display("FAIL %s: got out_port=%h pulse=%b, expected out_port=%h pulse=%b",
                  name, act_o, act_p, exp_o, exp_p);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset_n === 1'b1 && pressed_pulse[2] === 1'b1) n_pulse2++;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         if (e.at < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_missed: entry for cycle %0d seen at cycle %0d", e.at, cyc);
         end else begin
            check($sformatf("sb@%0d", e.at), out_port, e.out, pressed_pulse, e.pulse);
         end
      end
   end

   // Expect: old word one edge early, new word with pulse, then pulse gone.
   task automatic push_change(input logic [31:0] eo, input logic [3:0] ep);
      sb.push_back('{cyc + D + 2, exp_cur, 4'b0});
      sb.push_back('{cyc + D + 3, eo, ep});
      sb.push_back('{cyc + D + 4, eo, 4'b0});
      exp_cur = eo;
   endtask

   task automatic apply(input logic [3:0] kn, input logic [31:0] eo, input logic [3:0] ep);
      @(negedge clk);
      keys_n = kn;
      push_change(eo, ep);
      repeat (HOLD) @(negedge clk);
   endtask

   task automatic do_reset(input logic [3:0] kn);
      @(negedge clk);
      reset_n = 1'b0;
      keys_n  = kn;
      repeat (3) @(negedge clk);
      check("reset_state", out_port, 32'h0, pressed_pulse, 4'h0);
      exp_cur = 32'h0;
   endtask

   task automatic release_reset(input logic [31:0] eo, input logic [3:0] ep);
      @(negedge clk);
      reset_n = 1'b1;
      push_change(eo, ep);
      repeat (HOLD) @(negedge clk);
   endtask

   initial begin
      vt[0] = '{4'b1110, 32'h0000_0101, 4'b0001};   // clean press key 0
      vt[1] = '{4'b1111, 32'h0000_0100, 4'b0000};   // release: count kept, no pulse
      vt[2] = '{4'b0110, 32'h0400_0209, 4'b1001};   // keys 0 and 3 together
      vt[3] = '{4'b1111, 32'h0400_0200, 4'b0000};
      vt[4] = '{4'b1011, 32'h0410_0204, 4'b0100};   // key 2
      vt[5] = '{4'b1111, 32'h0410_0200, 4'b0000};

      reset_n = 1'b0;
      keys_n  = 4'b0000;

      // All keys held through reset release: one press each at edge 7.
      do_reset(4'b0000);
      release_reset(32'h0410_410F, 4'hF);
      apply(4'hF, 32'h0410_4100, 4'h0);

      do_reset(4'hF);
      release_reset(32'h0, 4'h0);

      for (int i = 0; i < 6; i++) apply(vt[i].kn, vt[i].eo, vt[i].ep);

      // Key 1 bounce: low 3 / high 2, never long enough to register.
      for (int j = 0; j < 10; j++) begin
         keys_n = 4'b1101;
         repeat (3) begin
            @(negedge clk);
            check("bounce", out_port, exp_cur, pressed_pulse, 4'h0);
         end
         keys_n = 4'b1111;
         repeat (2) begin
            @(negedge clk);
            check("bounce", out_port, exp_cur, pressed_pulse, 4'h0);
         end
      end
      repeat (D + 4) begin
         @(negedge clk);
         check("bounce_tail", out_port, exp_cur, pressed_pulse, 4'h0);
      end
      apply(4'b1101, 32'h0410_4202, 4'b0010);
      apply(4'b1111, 32'h0410_4200, 4'b0000);

      // Key 2 counter wraps 63 -> 0 on the 64th press.
      do_reset(4'hF);
      release_reset(32'h0, 4'h0);
      begin
         int base;
         base = n_pulse2;
         for (int p = 1; p <= 64; p++) begin
            apply(4'b1011, (32'(p % 64) << 20) | 32'h4, 4'b0100);
            apply(4'b1111, 32'(p % 64) << 20, 4'b0000);
         end
         n_tests++;
         if (n_pulse2 - base != 64) begin
            n_fail++;
            $display("FAIL wrap_pulses: got %0d pulses, expected 64", n_pulse2 - base);
         end
      end

      // Reset asserted mid-debounce of a key-1 press clears outputs at once.
      apply(4'b1110, 32'h0000_0101, 4'b0001);
      @(negedge clk);
      keys_n = 4'b1101;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check("async_reset", out_port, 32'h0, pressed_pulse, 4'h0);
      exp_cur = 32'h0;
      repeat (2) @(negedge clk);
      release_reset(32'h0000_4002, 4'b0010);
      apply(4'b1111, 32'h0000_4000, 4'b0000);

      repeat (5) @(negedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
